memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
// - MEM stage of the 5-stage RV32I pipeline: consumes the EX/MEM register, runs loads/stores on the data-memory bus, resolves branches/jumps, drives the MEM/WB register.
// - Owns the only multi-cycle path in the core: holds mem_stall while a bus access is outstanding; EX/MEM inputs are frozen by upstream while mem_stall=1.
// PARAMETERS
// - XLEN          32  datapath width
// - ACK_TIMEOUT   16  cycles in REQ without dmem_ack before the access is aborted
// PORTS
// - clk                 in   1   clock; all state on posedge
// - rst                 in   1   reset, synchronous, active-low
// - PCBranch_pype2      in   32  branch/jump target from EX
// - PCp4_pype2          in   32  PC+4 (link value)
// - ALU_co_pype         in   32  ALU result: memory address, or branch compare result
// - read_data2_pype2    in   32  store data (rs2)
// - WReg_pype2          in   5   destination register
// - RegWrite_pype2      in   1   register write enable
// - MemtoReg_pype2      in   2   WB select: 00 ALU, 01 load data, 10 PC+4
// - MemRW_pype2         in   2   00 none, 01 load, 10 store, 11 reserved (= none)
// - MemBranch_pype2     in   3   000 none,001 BEQ,010 BNE,011 BLT/BLTU,101 BGE/BGEU,110 JAL,100 JALR
// - Instraction_pype2   in   32  instruction; [14:12] = access size/sign
// - dmem_req            out  1   bus request
// - dmem_we             out  1   1 = write
// - dmem_addr           out  32  word-aligned address {ALU_co_pype[31:2],2'b00}
// - dmem_wdata          out  32  lane-replicated store data
// - dmem_be             out  4   byte enables
// - dmem_ack            in   1   access complete; dmem_rdata valid same cycle
// - dmem_rdata          in   32  read word
// - mem_stall           out  1   freeze IF..EX and EX/MEM this cycle
// - branch_taken        out  1   redirect fetch (combinational)
// - branch_PC           out  32  redirect target = PCBranch_pype2
// - ALU_co_pype3, read_data_pype3, PCp4_pype3  out 32  MEM/WB data
// - WReg_pype3 out 5; RegWrite_pype3 out 1; MemtoReg_pype3 out 2; Instraction_pype3 out 32
// - mem_err             out  1   one-cycle pulse: misaligned access or bus timeout
// BEHAVIOUR
// - Reset (rst=0 at posedge): FSM->IDLE, timeout counter 0, every registered output 0; dmem_req/we/be 0.
// - FSM IDLE: MemRW in {01,10} and aligned -> REQ, mem_stall=1, MEM/WB gets bubble (RegWrite_pype3=0).
//   Non-memory op: MEM/WB loads stage values next edge, latency 1, no stall.
// - REQ: dmem_req=1, addr/we/be/wdata from held inputs. dmem_ack=1 -> IDLE, mem_stall=0 that cycle,
//   MEM/WB loads (load data extended); memory ops take >=2 cycles. No ack -> counter++, mem_stall=1.
// - Counter reaching ACK_TIMEOUT-1 without ack: drop req, ->IDLE, mem_err pulse, bubble, mem_stall=0.
// - Ack in the same cycle as timeout: ack wins, no error.
// - Size (funct3): 000 B, 001 H, 010 W, 100 BU, 101 HU; others -> treated as W.
// - Store: byte be=1<<a[1:0], wdata={4{d[7:0]}}; half be=a[1]?1100:0011, wdata={2{d[15:0]}}; word be=1111.
// - Load: select lane by a[1:0]; B/H sign-extend, BU/HU zero-extend. dmem_be=1111 for loads.
// - Misaligned (H with a[0]=1, W with a[1:0]!=0): no bus access, no stall, bubble, mem_err pulse.
// - Branch: BEQ taken if ALU==0; BNE if !=0; 011 if ALU==1; 101 if ALU==0; JAL/JALR always.
//   branch_taken gated by !mem_stall; branches never stall. Flushing younger stages is the hazard unit's job.
// - Stores never write regs; RegWrite_pype3 forced 0 for MemRW=10 regardless of input.
// - rst low in REQ: access abandoned immediately (req drops at that edge), no mem_err.
// STRUCTURE
// - Encodings (MemRW, MemBranch, MemtoReg, size codes, FSM states) as `define in define.v.
// - Sub-module mem_align: combinational be/wdata generation, load extraction/extension, misalign detect.
// - Top: FSM + timeout counter + branch decode + MEM/WB register.
// TESTING
// - SW x=0xDEADBEEF @0x100, ack after 3 cycles -> be=1111, mem_stall 4 cycles high, RegWrite_pype3=0.
// - LB @0x103, rdata=0x80FF_FF11, ack 1st REQ cycle -> read_data_pype3=0xFFFFFF80; LBU -> 0x00000080.
// - SH 0x1234 @0x102 -> be=1100, wdata=0x12341234; LH @0x101 -> mem_err pulse, no dmem_req.
// - BNE with ALU_co_pype=5, PCBranch=0x40 -> branch_taken=1, branch_PC=0x40; ALU=0 -> taken=0.
// - No ack for 16 cycles -> req drops, mem_err 1 cycle, mem_stall low next cycle, bubble written.
// - rst=0 during REQ -> next cycle IDLE, dmem_req=0, all MEM/WB outputs 0, mem_err=0.

Source files
------------

// File: rtl/memory_access_pkg.sv
// Shared encodings for the MEM stage: control codes, access sizes, FSM states
// and the branch-condition decode.
package memory_access_pkg;

  localparam logic [1:0] MEMRW_LOAD  = 2'b01;
  localparam logic [1:0] MEMRW_STORE = 2'b10;

  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_BLT  = 3'b011;
  localparam logic [2:0] BR_JALR = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_JAL  = 3'b110;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  // EX leaves a compare result in the ALU output: 0/1 for BLT/BGE, a difference for BEQ/BNE.
  function automatic logic branch_cond(input logic [2:0] br, input logic [31:0] alu);
    case (br)
      BR_BEQ, BR_BGE:  return alu == 32'd0;
      BR_BNE:          return alu != 32'd0;
      BR_BLT:          return alu == 32'd1;
      BR_JAL, BR_JALR: return 1'b1;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_mem_align.sv
// Byte-lane steering for the data bus: store enables/replication, load lane
// extraction with sign/zero extension, and misalignment detection. Pure combinational.
module memory_access_mem_align
  import memory_access_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign lane     = rdata >> {addr_lo, 3'b000};
  assign byte_sel = lane[7:0];
  assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be         = 4'b1111;
    wdata      = store_data;
    load_data  = rdata;
    misaligned = 1'b0;
    case (size)
      SZ_B, SZ_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{byte_sel[7] && (size == SZ_B)}}, byte_sel};
      end
      SZ_H, SZ_HU: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        load_data  = {{16{half_sel[15] && (size == SZ_H)}}, half_sel};
        misaligned = addr_lo[0];
      end
      // word and every undefined size code
      default: misaligned = (addr_lo != 2'b00);
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// MEM stage: data-bus FSM with ack timeout, branch resolution and the MEM/WB register.
// Memory ops stall upstream until ack or timeout; other ops pass through in one cycle.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PCBranch_pype2,
  input  logic [XLEN-1:0] PCp4_pype2,
  input  logic [XLEN-1:0] ALU_co_pype,
  input  logic [XLEN-1:0] read_data2_pype2,
  input  logic [4:0]      WReg_pype2,
  input  logic            RegWrite_pype2,
  input  logic [1:0]      MemtoReg_pype2,
  input  logic [1:0]      MemRW_pype2,
  input  logic [2:0]      MemBranch_pype2,
  input  logic [31:0]     Instraction_pype2,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_PC,
  output logic [XLEN-1:0] ALU_co_pype3,
  output logic [XLEN-1:0] read_data_pype3,
  output logic [XLEN-1:0] PCp4_pype3,
  output logic [4:0]      WReg_pype3,
  output logic            RegWrite_pype3,
  output logic [1:0]      MemtoReg_pype3,
  output logic [31:0]     Instraction_pype3,
  output logic            mem_err
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               is_load, is_store, is_mem;
  logic               misaligned, timeout, err_now, wb_en;
  logic [3:0]         st_be;
  logic [31:0]        load_data;

  assign is_load  = (MemRW_pype2 == MEMRW_LOAD);
  assign is_store = (MemRW_pype2 == MEMRW_STORE);
  assign is_mem   = is_load || is_store;
  assign timeout  = (state == ST_REQ) && !dmem_ack && (tmo_cnt == CNT_W'(ACK_TIMEOUT - 1));

  memory_access_mem_align u_align (
    .addr_lo    (ALU_co_pype[1:0]),
    .size       (Instraction_pype2[14:12]),
    .store_data (read_data2_pype2),
    .rdata      (dmem_rdata),
    .be         (st_be),
    .wdata      (dmem_wdata),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (is_mem && !misaligned) state_nxt = ST_REQ;
      ST_REQ:  if (dmem_ack || timeout)   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The IDLE cycle of an access already stalls: the op needs the bus next cycle.
  always_comb begin
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    err_now   = 1'b0;
    case (state)
      ST_IDLE: begin
        mem_stall = is_mem && !misaligned;
        err_now   = is_mem && misaligned;
      end
      ST_REQ: begin
        dmem_req  = 1'b1;
        mem_stall = !dmem_ack && !timeout;
        err_now   = timeout;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst || state != ST_REQ || dmem_ack || timeout) tmo_cnt <= '0;
    else                                               tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign dmem_we      = dmem_req && is_store;
  assign dmem_be      = dmem_req ? (is_store ? st_be : 4'b1111) : 4'b0000;
  assign dmem_addr    = {ALU_co_pype[XLEN-1:2], 2'b00};
  assign branch_taken = branch_cond(MemBranch_pype2, ALU_co_pype) && !mem_stall;
  assign branch_PC    = PCBranch_pype2;
  assign wb_en        = !mem_stall && !err_now && !is_store;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ALU_co_pype3      <= '0;
      read_data_pype3   <= '0;
      PCp4_pype3        <= '0;
      WReg_pype3        <= '0;
      RegWrite_pype3    <= 1'b0;
      MemtoReg_pype3    <= '0;
      Instraction_pype3 <= '0;
      mem_err           <= 1'b0;
    end else begin
      ALU_co_pype3      <= ALU_co_pype;
      read_data_pype3   <= load_data;
      PCp4_pype3        <= PCp4_pype2;
      WReg_pype3        <= WReg_pype2;
      RegWrite_pype3    <= RegWrite_pype2 && wb_en;
      MemtoReg_pype3    <= MemtoReg_pype2;
      Instraction_pype3 <= Instraction_pype2;
      mem_err           <= err_now;
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed-vector bench for the MEM stage: bus protocol, lane steering, branches,
// timeout and reset-in-flight, against hand-computed expected values.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCBranch_pype2, PCp4_pype2, ALU_co_pype, read_data2_pype2;
  logic [4:0]  WReg_pype2;
  logic        RegWrite_pype2;
  logic [1:0]  MemtoReg_pype2, MemRW_pype2;
  logic [2:0]  MemBranch_pype2;
  logic [31:0] Instraction_pype2;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, branch_taken, mem_err;
  logic [31:0] branch_PC, ALU_co_pype3, read_data_pype3, PCp4_pype3, Instraction_pype3;
  logic [4:0]  WReg_pype3;
  logic        RegWrite_pype3;
  logic [1:0]  MemtoReg_pype3;

  int n_chk = 0;
  int n_bad = 0;
  int stalls, nreq;
  logic        req_s, we_s;
  logic [3:0]  be_s;
  logic [31:0] addr_s, wd_s;

  always #5 clk = ~clk;

  memory_access dut (
    .clk (clk), .rst (rst),
    .PCBranch_pype2 (PCBranch_pype2), .PCp4_pype2 (PCp4_pype2),
    .ALU_co_pype (ALU_co_pype), .read_data2_pype2 (read_data2_pype2),
    .WReg_pype2 (WReg_pype2), .RegWrite_pype2 (RegWrite_pype2),
    .MemtoReg_pype2 (MemtoReg_pype2), .MemRW_pype2 (MemRW_pype2),
    .MemBranch_pype2 (MemBranch_pype2), .Instraction_pype2 (Instraction_pype2),
    .dmem_req (dmem_req), .dmem_we (dmem_we), .dmem_addr (dmem_addr),
    .dmem_wdata (dmem_wdata), .dmem_be (dmem_be), .dmem_ack (dmem_ack),
    .dmem_rdata (dmem_rdata), .mem_stall (mem_stall),
    .branch_taken (branch_taken), .branch_PC (branch_PC),
    .ALU_co_pype3 (ALU_co_pype3), .read_data_pype3 (read_data_pype3),
    .PCp4_pype3 (PCp4_pype3), .WReg_pype3 (WReg_pype3),
    .RegWrite_pype3 (RegWrite_pype3), .MemtoReg_pype3 (MemtoReg_pype3),
    .Instraction_pype3 (Instraction_pype3), .mem_err (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_ops();
    MemRW_pype2 = 2'b00; MemBranch_pype2 = 3'b000; RegWrite_pype2 = 1'b0;
    ALU_co_pype = 32'h0; read_data2_pype2 = 32'h0; PCBranch_pype2 = 32'h0;
    PCp4_pype2 = 32'h0; WReg_pype2 = 5'd0; MemtoReg_pype2 = 2'b00;
    Instraction_pype2 = 32'h0;
  endtask

  task automatic set_op(input logic [1:0] rw, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    clear_ops();
    MemRW_pype2 = rw; ALU_co_pype = addr; read_data2_pype2 = wd;
    Instraction_pype2 = {17'b0, f3, 12'h003};
    RegWrite_pype2 = 1'b1; WReg_pype2 = 5'd9; PCp4_pype2 = 32'h204;
    MemtoReg_pype2 = (rw == 2'b01) ? 2'b01 : 2'b00;
  endtask

  // Called #1 after the negedge where the op was applied; acks on REQ cycle ack_at,
  // then clears the op at the following negedge so MEM/WB can be inspected.
  task automatic run_access(input int ack_at);
    stalls = mem_stall;
    for (int k = 1; k <= ack_at; k++) begin
      @(negedge clk);
      dmem_ack = (k == ack_at);
      #1;
      if (k == 1) begin
        req_s = dmem_req; we_s = dmem_we; be_s = dmem_be;
        addr_s = dmem_addr; wd_s = dmem_wdata;
      end
      stalls += mem_stall;
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    clear_ops();
    #1;
  endtask

  initial begin
    rst = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    clear_ops();
    ALU_co_pype = 32'hAAAA_5555; RegWrite_pype2 = 1'b1; PCp4_pype2 = 32'h44;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", dmem_req, 0);
    check("rst_be", dmem_be, 0);
    check("rst_alu3", ALU_co_pype3, 0);
    check("rst_pc4_3", PCp4_pype3, 0);
    check("rst_regw3", RegWrite_pype3, 0);
    check("rst_err", mem_err, 0);
    rst = 1'b1;

    // plain ALU op: one-cycle pass-through, no stall
    @(negedge clk);
    clear_ops();
    ALU_co_pype = 32'h1234_5678; RegWrite_pype2 = 1'b1; WReg_pype2 = 5'd7;
    PCp4_pype2 = 32'h108; Instraction_pype2 = 32'h0000_0033;
    #1 check("alu_stall", mem_stall, 0);
    @(negedge clk); #1;
    check("alu_alu3", ALU_co_pype3, 32'h1234_5678);
    check("alu_regw3", RegWrite_pype3, 1);
    check("alu_wreg3", WReg_pype3, 7);
    check("alu_pc4_3", PCp4_pype3, 32'h108);
    check("alu_inst3", Instraction_pype3, 32'h0000_0033);

    // SW 0xDEADBEEF @0x100, ack on 4th REQ cycle
    set_op(2'b10, 3'b010, 32'h100, 32'hDEAD_BEEF);
    #1 check("sw_idle_req", dmem_req, 0);
    run_access(4);
    check("sw_req", req_s, 1);
    check("sw_we", we_s, 1);
    check("sw_be", be_s, 4'b1111);
    check("sw_addr", addr_s, 32'h100);
    check("sw_wdata", wd_s, 32'hDEAD_BEEF);
    check("sw_stalls", stalls, 4);
    check("sw_regw3", RegWrite_pype3, 0);
    check("sw_err", mem_err, 0);
    check("sw_req_after", dmem_req, 0);

    // LB @0x103 acked first REQ cycle
    dmem_rdata = 32'h80FF_FF11;
    set_op(2'b01, 3'b000, 32'h103, 32'h0);
    #1 run_access(1);
    check("lb_be", be_s, 4'b1111);
    check("lb_we", we_s, 0);
    check("lb_addr", addr_s, 32'h100);
    check("lb_stalls", stalls, 1);
    check("lb_data", read_data_pype3, 32'hFFFF_FF80);
    check("lb_regw3", RegWrite_pype3, 1);
    check("lb_m2r3", MemtoReg_pype3, 2'b01);

    set_op(2'b01, 3'b100, 32'h103, 32'h0);
    #1 run_access(1);
    check("lbu_data", read_data_pype3, 32'h0000_0080);

    // LH @0x102: upper half, sign-extended
    set_op(2'b01, 3'b001, 32'h102, 32'h0);
    #1 run_access(2);
    check("lh_data", read_data_pype3, 32'hFFFF_80FF);
    check("lh_stalls", stalls, 2);

    // SH 0x1234 @0x102
    set_op(2'b10, 3'b001, 32'h102, 32'hFFFF_1234);
    #1 run_access(2);
    check("sh_be", be_s, 4'b1100);
    check("sh_wdata", wd_s, 32'h1234_1234);

    // SB 0xA5 @0x101
    set_op(2'b10, 3'b000, 32'h101, 32'h0000_00A5);
    #1 run_access(1);
    check("sb_be", be_s, 4'b0010);
    check("sb_wdata", wd_s, 32'hA5A5_A5A5);

    // LH @0x101 misaligned: no bus, no stall, error pulse, bubble
    @(negedge clk);
    set_op(2'b01, 3'b001, 32'h101, 32'h0);
    #1;
    check("mis_stall", mem_stall, 0);
    check("mis_req", dmem_req, 0);
    @(negedge clk);
    clear_ops();
    #1;
    check("mis_err", mem_err, 1);
    check("mis_regw3", RegWrite_pype3, 0);
    check("mis_req2", dmem_req, 0);
    @(negedge clk); #1;
    check("mis_err_pulse", mem_err, 0);

    // branches
    PCBranch_pype2 = 32'h40; MemBranch_pype2 = 3'b010; ALU_co_pype = 32'd5;
    #1;
    check("bne_taken", branch_taken, 1);
    check("bne_pc", branch_PC, 32'h40);
    ALU_co_pype = 32'd0;
    #1 check("bne_not", branch_taken, 0);
    MemBranch_pype2 = 3'b001;
    #1 check("beq_taken", branch_taken, 1);
    MemBranch_pype2 = 3'b011; ALU_co_pype = 32'd1;
    #1 check("blt_taken", branch_taken, 1);
    MemBranch_pype2 = 3'b101;
    #1 check("bge_not", branch_taken, 0);
    MemBranch_pype2 = 3'b110; ALU_co_pype = 32'h77;
    #1 check("jal_taken", branch_taken, 1);
    MemBranch_pype2 = 3'b000;
    #1 check("none_not", branch_taken, 0);

    // timeout: load never acked
    @(negedge clk);
    set_op(2'b01, 3'b010, 32'h200, 32'h0);
    #1 stalls = mem_stall;
    nreq = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); #1;
      nreq += dmem_req;
      stalls += mem_stall;
      if (k == 16) check("to_err_early", mem_err, 0);
    end
    check("to_req_cycles", nreq, 16);
    check("to_stalls", stalls, 16);
    @(negedge clk);
    clear_ops();
    #1;
    check("to_req_drop", dmem_req, 0);
    check("to_err", mem_err, 1);
    check("to_regw3", RegWrite_pype3, 0);
    check("to_stall_low", mem_stall, 0);
    @(negedge clk); #1;
    check("to_err_pulse", mem_err, 0);

    // reset while in REQ
    set_op(2'b01, 3'b010, 32'h300, 32'h0);
    @(negedge clk); #1;
    check("rq_req", dmem_req, 1);
    rst = 1'b0;
    @(negedge clk); #1;
    check("rq_req_drop", dmem_req, 0);
    check("rq_alu3", ALU_co_pype3, 0);
    check("rq_pc4_3", PCp4_pype3, 0);
    check("rq_inst3", Instraction_pype3, 0);
    check("rq_wreg3", WReg_pype3, 0);
    check("rq_err", mem_err, 0);
    clear_ops();
    rst = 1'b1;
    @(negedge clk); #1;
    check("rq_idle_req", dmem_req, 0);
    check("rq_idle_err", mem_err, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
